// File: rtl/lcb_frame_collector.sv
// rtl/lcb_frame_collector.sv - collects a fixed-length UART reply frame into RAM and checks its checksum
// Each byte is written one cycle after its strob; the last byte is the mod-256 sum of the others.
module lcb_frame_collector #(
   parameter int unsigned BYTES   = 5'd20,
   parameter logic [15:0] RESP_TO = 16'd4000,
   parameter logic [15:0] GAP_TO  = 16'd400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       strob,
   input  logic [7:0] iData,
   output logic       WE,
   output logic [4:0] wrAdr,
   output logic [7:0] oData,
   output logic       done,
   output logic       err,
   output logic [1:0] errCode,
   output logic [5:0] count,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, WAIT_FIRST, RECV, CHECK} state_t;

   localparam logic [5:0]  NBYTES   = 6'(BYTES);
   // The arm/strob cycle itself counts as the first waited cycle, so err lands
   // exactly RESP_TO (or GAP_TO) cycles after the event that started the wait.
   localparam logic [15:0] RESP_LIM = RESP_TO - 16'd1;
   localparam logic [15:0] GAP_LIM  = GAP_TO - 16'd1;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d, timer_inc;
   logic [5:0]  cnt_q, cnt_d;
   logic [7:0]  sum_q, sum_d;
   logic        we_q, we_d;
   logic [4:0]  adr_q, adr_d;
   logic [7:0]  dat_q, dat_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic [5:0]  count_q, count_d;

   always_comb begin
      timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
      state_d   = state_q;
      timer_d   = timer_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      we_d      = 1'b0;
      adr_d     = adr_q;
      dat_d     = dat_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;
      count_d   = count_q;

      if (arm) begin
         state_d = WAIT_FIRST;
         timer_d = 16'd0;
         cnt_d   = 6'd0;
         sum_d   = 8'd0;
         code_d  = 2'b00;
         count_d = 6'd0;
      end else begin
         case (state_q)
            IDLE: ;
            WAIT_FIRST, RECV: begin
               if (strob) begin
                  we_d    = 1'b1;
                  adr_d   = cnt_q[4:0];
                  dat_d   = iData;
                  cnt_d   = cnt_q + 6'd1;
                  timer_d = 16'd0;
                  if (cnt_q != NBYTES - 6'd1)
                     sum_d = sum_q + iData;
                  state_d = (cnt_d == NBYTES) ? CHECK : RECV;
               end else begin
                  timer_d = timer_inc;
                  if (timer_inc >= ((state_q == WAIT_FIRST) ? RESP_LIM : GAP_LIM)) begin
                     err_d   = 1'b1;
                     code_d  = (state_q == WAIT_FIRST) ? 2'b01 : 2'b10;
                     count_d = cnt_q;
                     state_d = IDLE;
                  end
               end
            end
            CHECK: begin
               // dat_q still holds the final byte, which never entered sum_q
               count_d = NBYTES;
               state_d = IDLE;
               if (dat_q == sum_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'b11;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= 16'd0;
         cnt_q   <= 6'd0;
         sum_q   <= 8'd0;
         we_q    <= 1'b0;
         adr_q   <= 5'd0;
         dat_q   <= 8'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
         count_q <= 6'd0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         count_q <= count_d;
      end
   end

   assign WE      = we_q;
   assign wrAdr   = adr_q;
   assign oData   = dat_q;
   assign done    = done_q;
   assign err     = err_q;
   assign errCode = code_q;
   assign count   = count_q;
   assign busy    = (state_q != IDLE);

endmodule
